mul_sequencer: RTL and testbench
================================

# mul_sequencer

Multi-cycle 64-bit multiply controller that computes the low `REGDATASIZE` bits of a product with a shift-add algorithm. It borrows the execute-stage ALU for its arithmetic instead of instantiating its own adder or shifters. While it runs, the execute-stage operand mux selects this block's ALU drive, and the pipeline stalls on `busy`.

## Interface
Parameters:
- `ITERS`, default `` `REGDATASIZE ``: maximum number of multiplier bits processed.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low
- `start`  in  1  request a multiply; sampled only in IDLE
- `flush`  in  1  synchronous abort to IDLE; no `done` is produced
- `multiplicand`  in  `` `REGDATASIZE ``  operand A; captured on accepted `start`
- `multiplier`  in  `` `REGDATASIZE ``  operand B; captured on accepted `start`
- `alu_result`  in  `` `REGDATASIZE ``  ALU result, combinational from this block's drive
- `alu_flags`  in  `` `FLAGSIZE ``  ALU flags; only `` `ZERO `` is used
- `alu_op`  out  `` `ALUOPSIZE ``  ALU operation select
- `alu_operand1`  out  `` `REGDATASIZE ``  ALU operand 1
- `alu_operand2`  out  `` `REGDATASIZE ``  ALU operand 2
- `alu_own`  out  1  steers the ALU input mux to this block
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse: `product` is valid
- `product`  out  `` `REGDATASIZE ``  registered result; held until the next accepted `start`

## Operation
- Internal registers: `acc`, `mc` (shifted multiplicand), `mp` (shifted multiplier), and `cnt` (0..`ITERS`-1).
- States: IDLE, ADD, SHL, SHR, DONE.
- **IDLE**
  - `start` captures `mc`=A, `mp`=B, `acc`=0, `cnt`=0.
  - Next state: DONE if `mp`==0 (early exit only), else ADD if B[0], else SHL.
- **ADD**
  - Drive `` `ALUOP_ADD ``, op1=`acc`, op2=`mc`; load `acc`←`alu_result`.
  - Next state: SHL.
- **SHL**
  - Drive `` `ALUOP_LSHIFT ``, op1=`mc`, op2=1; load `mc`←`alu_result`.
  - Next state: SHR.
- **SHR**
  - Drive `` `ALUOP_RSHIFT ``, op1=`mp`, op2=1; load `mp`←`alu_result`; `cnt`++.
  - Next state: DONE if `cnt`==`ITERS`-1 or (early exit and `alu_flags[`ZERO]`); else ADD if `alu_result[0]`, else SHL.
- **DONE**
  - `done`=1 and `product`←`acc`.
  - Next state: IDLE.
- `alu_own`=1 in ADD/SHL/SHR only. In all other states, drive `alu_op`=`` `ALUOP_ADD `` and both operands 0.
- Arithmetic wraps modulo 2^`REGDATASIZE`. Carry and overflow are ignored, so signed and unsigned results agree in the low bits.
- `start` while busy: ignored, with no queueing.
- `flush`:
  - From any state, goes to IDLE on the next edge; `product` is unchanged.
  - `flush` has priority over `start` in the same cycle.
  - `flush` in DONE: `done` is still high that cycle, and `product` still updates.
- Reset (also mid-operation): state=IDLE; `acc`, `mc`, `mp`, `cnt`, `product` = 0; `done`=0, `busy`=0, `alu_own`=0.

## Timing
- Every state lasts exactly one cycle; there are no ALU wait states.
- The cycle after the accepting edge is cycle 1.
- `done` is high in cycle 2N+P+1:
  - N = iterations run;
  - P = number of set bits among the processed multiplier bits.
- N is `ITERS` without early exit; with early exit, N = bit position of the highest set bit of B, plus 1.
- `busy` rises in cycle 1 and stays high through the DONE cycle.
- `product` changes on the edge that leaves DONE; it is visible from the cycle after `done`.
- A new `start` is accepted in the first cycle back in IDLE, so there is a one-idle-cycle gap between back-to-back operations.

## Configuration
- `MUL_EARLY_EXIT_EN` defined:
  - SHR terminates when the shifted multiplier is zero, using the ALU `` `ZERO `` flag.
  - B==0 goes IDLE→DONE directly, with `done` in cycle 1 and product 0.
- `MUL_EARLY_EXIT_EN` undefined:
  - Always `ITERS` iterations; the `` `ZERO `` flag is unused.
  - B==0 takes 2·`ITERS`+1 cycles.

## Test plan
- 3×5, early exit: `done` in cycle 9 (N=3, P=2); `product`=15; `alu_own` high in cycles 1–8 only.
- 3×5, no early exit, `ITERS`=64: `done` in cycle 131; `product`=15.
- 0xFFFF_FFFF_FFFF_FFFF×2, early exit: `done` in cycle 6; `product`=0xFFFF_FFFF_FFFF_FFFE (wraps).
- B=0, early exit: `done` in cycle 1; `product`=0.
- `start` 7×9, then second `start` 2×2 in cycle 3:
  - the second request is ignored;
  - `done` fires once, in cycle 11 (N=4, P=2), with `product`=63.
- `flush` in cycle 4 of 7×9:
  - IDLE in cycle 5, no `done`, `product` keeps its previous value.
- `rst_n` low mid-operation:
  - all outputs 0 immediately;
  - a new 6×7 afterwards yields 42.

Source files
------------

// File: rtl/mul_sequencer.sv
// Shift-add 64-bit multiply sequencer that borrows the execute-stage ALU for every add/shift step.
// Optional build macro: MUL_EARLY_EXIT_EN (stop once the shifted multiplier is zero, B==0 shortcut).

`ifndef REGDATASIZE
`define REGDATASIZE 64
`endif
`ifndef FLAGSIZE
`define FLAGSIZE 4
`endif
`ifndef ZERO
`define ZERO 0
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 4
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'd0
`endif
`ifndef ALUOP_LSHIFT
`define ALUOP_LSHIFT 4'd5
`endif
`ifndef ALUOP_RSHIFT
`define ALUOP_RSHIFT 4'd6
`endif

module mul_sequencer #(
   parameter int ITERS = `REGDATASIZE
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     flush,
   input  logic [`REGDATASIZE-1:0]  multiplicand,
   input  logic [`REGDATASIZE-1:0]  multiplier,
   input  logic [`REGDATASIZE-1:0]  alu_result,
   input  logic [`FLAGSIZE-1:0]     alu_flags,
   output logic [`ALUOPSIZE-1:0]    alu_op,
   output logic [`REGDATASIZE-1:0]  alu_operand1,
   output logic [`REGDATASIZE-1:0]  alu_operand2,
   output logic                     alu_own,
   output logic                     busy,
   output logic                     done,
   output logic [`REGDATASIZE-1:0]  product
);

   localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADD  = 3'd1;
   localparam logic [2:0] S_SHL  = 3'd2;
   localparam logic [2:0] S_SHR  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]               state, state_nxt;
   logic [`REGDATASIZE-1:0]  acc, mc, mp;
   logic [CNT_W-1:0]         cnt;
   logic                     last_iter;
   logic                     exit_idle, exit_shr;
   logic                     unused_flags;

   assign last_iter    = (cnt == CNT_W'(ITERS - 1));
   assign unused_flags = ^alu_flags;

`ifdef MUL_EARLY_EXIT_EN
   // The ALU zero flag on the SHR step tells us no multiplier bits remain.
   assign exit_idle = (multiplier == '0);
   assign exit_shr  = alu_flags[`ZERO];
`else
   assign exit_idle = 1'b0;
   assign exit_shr  = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: if (start) state_nxt = exit_idle ? S_DONE : (multiplier[0] ? S_ADD : S_SHL);
         S_ADD:  state_nxt = S_SHL;
         S_SHL:  state_nxt = S_SHR;
         S_SHR: begin
            if (last_iter || exit_shr) state_nxt = S_DONE;
            else                       state_nxt = alu_result[0] ? S_ADD : S_SHL;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
      if (flush) state_nxt = S_IDLE;
   end

   always_comb begin
      alu_op       = `ALUOP_ADD;
      alu_operand1 = '0;
      alu_operand2 = '0;
      case (state)
         S_ADD: begin
            alu_op       = `ALUOP_ADD;
            alu_operand1 = acc;
            alu_operand2 = mc;
         end
         S_SHL: begin
            alu_op       = `ALUOP_LSHIFT;
            alu_operand1 = mc;
            alu_operand2 = `REGDATASIZE'(1);
         end
         S_SHR: begin
            alu_op       = `ALUOP_RSHIFT;
            alu_operand1 = mp;
            alu_operand2 = `REGDATASIZE'(1);
         end
         default: ;
      endcase
   end

   assign alu_own = (state == S_ADD) || (state == S_SHL) || (state == S_SHR);
   assign busy    = (state != S_IDLE);
   assign done    = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         acc     <= '0;
         mc      <= '0;
         mp      <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         state <= state_nxt;
         // A flush in DONE still publishes the finished result.
         if (state == S_DONE) product <= acc;
         if (!flush) begin
            case (state)
               S_IDLE: if (start) begin
                  mc  <= multiplicand;
                  mp  <= multiplier;
                  acc <= '0;
                  cnt <= '0;
               end
               S_ADD: acc <= alu_result;
               S_SHL: mc  <= alu_result;
               S_SHR: begin
                  mp  <= alu_result;
                  cnt <= cnt + CNT_W'(1);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed bench for mul_sequencer with a behavioural execute-stage ALU; expectations follow MUL_EARLY_EXIT_EN.

`ifndef REGDATASIZE
`define REGDATASIZE 64
`endif
`ifndef FLAGSIZE
`define FLAGSIZE 4
`endif
`ifndef ZERO
`define ZERO 0
`endif
`ifndef ALUOPSIZE
`define ALUOPSIZE 4
`endif
`ifndef ALUOP_ADD
`define ALUOP_ADD 4'd0
`endif
`ifndef ALUOP_LSHIFT
`define ALUOP_LSHIFT 4'd5
`endif
`ifndef ALUOP_RSHIFT
`define ALUOP_RSHIFT 4'd6
`endif

module tb_mul_sequencer;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     flush = 1'b0;
   logic [`REGDATASIZE-1:0]  multiplicand = '0;
   logic [`REGDATASIZE-1:0]  multiplier = '0;
   logic [`REGDATASIZE-1:0]  alu_result;
   logic [`FLAGSIZE-1:0]     alu_flags;
   logic [`ALUOPSIZE-1:0]    alu_op;
   logic [`REGDATASIZE-1:0]  alu_operand1, alu_operand2;
   logic                     alu_own, busy, done;
   logic [`REGDATASIZE-1:0]  product;

   int checks = 0;
   int errors = 0;

`ifdef MUL_EARLY_EXIT_EN
   localparam int C_3X5 = 9, C_FFX2 = 6, C_B0 = 1, C_7X9 = 11, C_6X7 = 10;
`else
   localparam int C_3X5 = 131, C_FFX2 = 130, C_B0 = 129, C_7X9 = 131, C_6X7 = 132;
`endif

   mul_sequencer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .flush        (flush),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .alu_result   (alu_result),
      .alu_flags    (alu_flags),
      .alu_op       (alu_op),
      .alu_operand1 (alu_operand1),
      .alu_operand2 (alu_operand2),
      .alu_own      (alu_own),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_result = '0;
      case (alu_op)
         `ALUOP_ADD:    alu_result = alu_operand1 + alu_operand2;
         `ALUOP_LSHIFT: alu_result = alu_operand1 << alu_operand2[5:0];
         `ALUOP_RSHIFT: alu_result = alu_operand1 >> alu_operand2[5:0];
         default:       alu_result = '0;
      endcase
      alu_flags = '0;
      alu_flags[`ZERO] = (alu_result == '0);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Leaves the bench at the falling edge inside cycle 1.
   task automatic start_op(input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      multiplicand = a;
      multiplier   = b;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int from_cyc, input int limit, output int cyc, output logic own_ok);
      cyc    = 0;
      own_ok = 1'b1;
      for (int c = from_cyc; c <= limit; c++) begin
         if (!busy || (alu_own !== !done)) own_ok = 1'b0;
         if (done) begin
            cyc = c;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_mul(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_p, input int exp_cyc);
      int   cyc;
      logic own_ok;
      start_op(a, b);
      wait_done(1, 400, cyc, own_ok);
      check({tag, "_done_cycle"}, cyc, exp_cyc);
      check({tag, "_alu_own"}, own_ok, 1'b1);
      @(negedge clk);
      check({tag, "_product"}, product, exp_p);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_idle"}, busy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   cyc;
      int   extra;
      logic own_ok;

      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_own", alu_own, 1'b0);
      check("rst_product", product, 64'd0);
      check("rst_alu_op", alu_op, `ALUOP_ADD);
      check("rst_op1", alu_operand1, 64'd0);
      check("rst_op2", alu_operand2, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_mul("m3x5", 64'd3, 64'd5, 64'd15, C_3X5);
      run_mul("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, C_FFX2);
      run_mul("b0", 64'd1234, 64'd0, 64'd0, C_B0);

      // Second start in cycle 3 must be dropped.
      start_op(64'd7, 64'd9);
      @(negedge clk);
      @(negedge clk);
      multiplicand = 64'd2;
      multiplier   = 64'd2;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(4, 400, cyc, own_ok);
      check("busy_start_cycle", cyc, C_7X9);
      @(negedge clk);
      check("busy_start_product", product, 64'd63);
      extra = 0;
      for (int i = 0; i < 20; i++) begin
         if (done) extra++;
         @(negedge clk);
      end
      check("busy_start_single_done", extra, 0);

      // Flush in cycle 4 returns to IDLE with no done.
      start_op(64'd7, 64'd9);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", busy, 1'b0);
      check("flush_own", alu_own, 1'b0);
      extra = 0;
      for (int i = 0; i < 150; i++) begin
         if (done) extra++;
         @(negedge clk);
      end
      check("flush_no_done", extra, 0);
      check("flush_product_held", product, 64'd63);

      // Asynchronous reset mid-operation.
      start_op(64'd3, 64'd5);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_own", alu_own, 1'b0);
      check("midrst_product", product, 64'd0);
      check("midrst_alu_op", alu_op, `ALUOP_ADD);
      check("midrst_op1", alu_operand1, 64'd0);
      check("midrst_op2", alu_operand2, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_mul("m6x7", 64'd6, 64'd7, 64'd42, C_6X7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
